ms_sar_ctrl: RTL and testbench



---
 rtl/ms_sar_pkg.sv | 23 ++
 rtl/ms_sync.sv | 27 ++
 rtl/ms_sar_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ms_sar_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_sar_pkg.sv
// Shared types and constants for the successive-approximation controller.
package ms_sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2,
    DONE   = 2'd3
  } sar_state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 1;
  localparam int DEF_SYNC_STAGES   = 2;

  // Conversions averaged per start when MS_SAR_AVG_EN is defined.
  localparam int AVG_COUNT = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ms_sync.sv
// Multi-stage flop synchronizer for a single asynchronous bit.
// Reusable by any consumer of the comparator pin.
module ms_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/ms_sar_ctrl.sv
// Successive-approximation ADC controller: drives the DAC code on
// port_ms_o, reads the comparator on port_ms_i through a synchronizer and
// sequences track / per-bit trial / decide phases.
// Optional build macro: MS_SAR_AVG_EN (average of AVG_COUNT conversions).
module ms_sar_ctrl
  import ms_sar_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             continuous_i,
  input  logic             port_ms_i,
  output logic [WIDTH-1:0] port_ms_o,
  output logic             sample_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  // Cycles each bit trial is held: DAC settle plus synchronizer latency.
  localparam int BIT_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_MAX    = max2(SAMPLE_CYCLES, BIT_CYCLES);
  localparam int CNT_W      = $clog2(CNT_MAX) + 1;
  localparam int BIT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_MSB     = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_MASK    = WIDTH'(1) << (WIDTH - 1);

  sar_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIT_W-1:0] r_bit;

  logic             w_cmp;
  logic [WIDTH-1:0] w_bit_mask;
  logic [WIDTH-1:0] w_kept;

  ms_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_async(port_ms_i),
    .o_sync (w_cmp)
  );

  // Current trial bit and the code after deciding it from the comparator.
  assign w_bit_mask = WIDTH'(1) << r_bit;
  assign w_kept     = w_cmp ? port_ms_o : (port_ms_o & ~w_bit_mask);

`ifdef MS_SAR_AVG_EN
  localparam logic [1:0] PASS_LAST = 2'(AVG_COUNT - 1);

  logic [WIDTH+1:0] r_acc;
  logic [1:0]       r_pass;
  logic [WIDTH+1:0] w_sum;

  assign w_sum = r_acc + {2'b00, w_kept};
`endif

  // Conversion sequencer; every output is a registered copy of FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      port_ms_o <= '0;
      sample_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
`ifdef MS_SAR_AVG_EN
      r_acc     <= '0;
      r_pass    <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        // Abort wins over start and continuous; result_o is left alone.
        r_state   <= IDLE;
        r_cnt     <= '0;
        port_ms_o <= '0;
        sample_o  <= 1'b0;
        busy_o    <= 1'b0;
`ifdef MS_SAR_AVG_EN
        r_acc     <= '0;
        r_pass    <= '0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              r_state   <= SAMPLE;
              r_cnt     <= '0;
              port_ms_o <= '0;
              sample_o  <= 1'b1;
              busy_o    <= 1'b1;
            end
          end

          SAMPLE: begin
            if (r_cnt == SAMPLE_LAST) begin
              r_state   <= CONV;
              r_cnt     <= '0;
              r_bit     <= BIT_MSB;
              port_ms_o <= MSB_MASK;
              sample_o  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          CONV: begin
            if (r_cnt != BIT_LAST) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else if (r_bit != '0) begin
              // Decide this bit and present the next trial in one step.
              r_cnt     <= '0;
              r_bit     <= r_bit - BIT_W'(1);
              port_ms_o <= w_kept | (w_bit_mask >> 1);
            end else begin
              r_cnt <= '0;
`ifdef MS_SAR_AVG_EN
              if (r_pass != PASS_LAST) begin
                r_acc     <= w_sum;
                r_pass    <= r_pass + 2'd1;
                r_state   <= SAMPLE;
                port_ms_o <= '0;
                sample_o  <= 1'b1;
              end else begin
                r_acc     <= '0;
                r_pass    <= '0;
                r_state   <= DONE;
                port_ms_o <= '0;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
                result_o  <= w_sum[WIDTH+1:2];
              end
`else
              r_state   <= DONE;
              port_ms_o <= '0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              result_o  <= w_kept;
`endif
            end
          end

          DONE: begin
            if (continuous_i) begin
              r_state  <= SAMPLE;
              r_cnt    <= '0;
              sample_o <= 1'b1;
              busy_o   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ms_sar_ctrl.sv
// Directed self-checking bench for ms_sar_ctrl with an ideal comparator
// model (port_ms_i = vin >= port_ms_o). Build with MS_SAR_AVG_EN to check
// the averaging variant with the same sequence.
module tb_ms_sar_ctrl;

`ifdef MS_SAR_AVG_EN
  localparam int LAT = 113;
`else
  localparam int LAT = 29;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       abort_i;
  logic       continuous_i;
  logic       port_ms_i;
  logic [7:0] port_ms_o;
  logic       sample_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] result_o;
  logic [7:0] vin;

  int total = 0;
  int bad   = 0;

  ms_sar_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .continuous_i(continuous_i),
    .port_ms_i   (port_ms_i),
    .port_ms_o   (port_ms_o),
    .sample_o    (sample_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  // Ideal analog comparator.
  assign port_ms_i = (vin >= port_ms_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One started conversion; checks latency from start sampling and result.
  task automatic conv_once(input logic [7:0] v, input logic [7:0] exp_res, input string tag);
    int n;
    vin     = v;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    while (done_o !== 1'b1 && n < LAT + 20) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_lat"}, n, LAT);
    check({tag, "_res"}, result_o, exp_res);
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] trials [8];
    int n;
    int done_cnt;
    int first_done;

    trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    rst_ni       = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    continuous_i = 1'b0;
    vin          = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check("rst_port",   port_ms_o, 8'h00);
    check("rst_sample", sample_o,  1'b0);
    check("rst_busy",   busy_o,    1'b0);
    check("rst_done",   done_o,    1'b0);
    check("rst_result", result_o,  8'h00);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // vin=0xA5: trial sequence, latency and result.
    vin     = 8'hA5;
    start_i = 1'b1;
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (j == 1) begin
        check("a5_sample_on", sample_o,  1'b1);
        check("a5_busy_on",   busy_o,    1'b1);
        check("a5_port_smp",  port_ms_o, 8'h00);
      end
      if (j == 4) check("a5_sample_last", sample_o, 1'b1);
      if (j >= 5 && j <= 28) begin
        check($sformatf("a5_trial_c%0d", j), port_ms_o, trials[(j - 5) / 3]);
        check("a5_sample_off", sample_o, 1'b0);
      end
      if (j < LAT) check("a5_no_early_done", done_o, 1'b0);
    end
    check("a5_done",   done_o,    1'b1);
    check("a5_result", result_o,  8'hA5);
    check("a5_busy",   busy_o,    1'b0);
    check("a5_port",   port_ms_o, 8'h00);
    @(negedge clk_i);
    check("a5_done_pulse", done_o,   1'b0);
    check("a5_idle_smp",   sample_o, 1'b0);
    check("a5_hold_res",   result_o, 8'hA5);

    // Abort during bit 3 of vin=0x3C conversion.
    vin     = 8'h3C;
    start_i = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    check("ab_bit3_trial", port_ms_o, 8'h38);
    check("ab_busy_pre",   busy_o,    1'b1);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("ab_busy",   busy_o,    1'b0);
    check("ab_port",   port_ms_o, 8'h00);
    check("ab_sample", sample_o,  1'b0);
    done_cnt = 0;
    for (int j = 0; j < LAT + 10; j++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) done_cnt++;
    end
    check("ab_no_done", done_cnt, 0);
    check("ab_result",  result_o, 8'hA5);

    // Abort beats start in IDLE.
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    check("prio_busy",   busy_o,   1'b0);
    check("prio_sample", sample_o, 1'b0);

    // Extremes.
    conv_once(8'h00, 8'h00, "zero");
    conv_once(8'hFF, 8'hFF, "full");
    conv_once(8'h40, 8'h40, "x40");

    // start_i held high with a re-pulse while busy: exactly one done.
    vin        = 8'h5A;
    start_i    = 1'b1;
    done_cnt   = 0;
    first_done = 0;
    for (int j = 1; j <= LAT + 15; j++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = j;
        start_i = 1'b0;
      end
      if (j == 9)  start_i = 1'b0;
      if (j == 10) start_i = 1'b1;
    end
    start_i = 1'b0;
    check("hold_done_cnt", done_cnt,   1);
    check("hold_done_at",  first_done, LAT);
    check("hold_result",   result_o,   8'h5A);

    // Continuous mode: 0x33 then 0x34.
    vin          = 8'h33;
    continuous_i = 1'b1;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    while (done_o !== 1'b1 && n < LAT + 20) begin
      @(negedge clk_i);
      n++;
    end
    check("cont1_lat", n,        LAT);
    check("cont1_res", result_o, 8'h33);
    check("cont1_busy_done", busy_o, 1'b0);
    vin = 8'h34;
    @(negedge clk_i);
    check("cont1_sample_rise", sample_o, 1'b1);
    check("cont1_busy_again",  busy_o,   1'b1);
    n = 1;
    while (done_o !== 1'b1 && n < LAT + 20) begin
      @(negedge clk_i);
      n++;
    end
    check("cont2_gap", n,        LAT);
    check("cont2_res", result_o, 8'h34);
    @(negedge clk_i);
    check("cont2_sample_rise", sample_o, 1'b1);
    continuous_i = 1'b0;
    abort_i      = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("cont_stop_busy", busy_o,   1'b0);
    check("cont_stop_res",  result_o, 8'h34);

    // Asynchronous reset mid-conversion.
    vin     = 8'hA5;
    start_i = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    check("mr_busy_pre", busy_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mr_port",   port_ms_o, 8'h00);
    check("mr_sample", sample_o,  1'b0);
    check("mr_busy",   busy_o,    1'b0);
    check("mr_done",   done_o,    1'b0);
    check("mr_result", result_o,  8'h00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("mr_idle_busy", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
